ex_muldiv_sequencer: RTL

Multi-cycle integer multiply/divide unit with its own sequencing FSM. It sits beside the execute-stage ALU and takes the same ID/EX operands and opcode. It accepts MUL and UDIV, runs a 64-iteration shift-add or restoring-divide loop, and holds the pipeline stall line until the result is ready. The single-cycle ALU path is unchanged; this block only claims MUL/UDIV instructions.

---
 rtl/ex_muldiv_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_sequencer.sv
// rtl/ex_muldiv_sequencer.sv - multi-cycle MUL/UDIV unit with its own sequencing FSM
module ex_muldiv_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [10:0] OPC_MUL  = 11'b10011011000;
    localparam logic [10:0] OPC_UDIV = 11'b10011010110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplier_a;
    logic [WIDTH-1:0] mcand_b;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    // Holds the dividend; quotient bits shift in from the LSB as dividend bits leave the MSB.
    logic [WIDTH-1:0] dvd_quo;

    logic is_mul;
    logic is_div;
    logic divisor_zero;
    logic last_iter;
    logic accept_mul;
    logic accept_div;
    logic accept_dz;
    logic finish;

    logic [WIDTH-1:0] acc_step;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign is_mul       = (opcode == OPC_MUL);
    assign is_div       = (opcode == OPC_UDIV);
    assign divisor_zero = (operand_b == '0);
    assign last_iter    = (count == CNT_W'(WIDTH - 1));

    assign acc_step  = mcand_b[0] ? (acc + mplier_a) : acc;
    assign rem_shift = {rem, dvd_quo[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor};
    // rem < divisor keeps rem_shift below 2*divisor, so the borrow bit alone decides rem >= divisor.
    assign rem_ge    = ~rem_diff[WIDTH];
    assign rem_step  = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_step  = {dvd_quo[WIDTH-2:0], rem_ge};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        accept_mul = 1'b0;
        accept_div = 1'b0;
        accept_dz  = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    if (is_mul) begin
                        stall      = 1'b1;
                        accept_mul = 1'b1;
                        state_next = S_MUL;
                    end else if (is_div) begin
                        stall = 1'b1;
                        if (divisor_zero) begin
                            accept_dz  = 1'b1;
                            state_next = S_DONE;
                        end else begin
                            accept_div = 1'b1;
                            state_next = S_DIV;
                        end
                    end
                end
            end
            S_MUL, S_DIV: begin
                stall = 1'b1;
                if (flush) begin
                    state_next = S_IDLE;
                end else if (last_iter) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            acc      <= '0;
            mplier_a <= '0;
            mcand_b  <= '0;
            rem      <= '0;
            divisor  <= '0;
            dvd_quo  <= '0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_mul) begin
                mplier_a <= operand_a;
                mcand_b  <= operand_b;
                acc      <= '0;
                count    <= '0;
            end
            if (accept_div) begin
                dvd_quo <= operand_a;
                divisor <= operand_b;
                rem     <= '0;
                count   <= '0;
            end
            if (accept_dz) begin
                result <= '0;
                done   <= 1'b1;
            end
            if (state == S_MUL && !flush) begin
                acc      <= acc_step;
                mplier_a <= {mplier_a[WIDTH-2:0], 1'b0};
                mcand_b  <= {1'b0, mcand_b[WIDTH-1:1]};
                count    <= count + CNT_W'(1);
                if (finish) begin
                    result <= acc_step;
                    done   <= 1'b1;
                end
            end
            if (state == S_DIV && !flush) begin
                rem     <= rem_step;
                dvd_quo <= quo_step;
                count   <= count + CNT_W'(1);
                if (finish) begin
                    result <= quo_step;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule
